firmware_loader: RTL and testbench
==================================

FIRMWARE_LOADER -- requirements
Module: firmware_loader

Interface
REQ-001 The module SHALL have parameter MEM_WORDS, default 51200, giving the number of 32-bit words in the target on-chip memory.
REQ-002 The module SHALL have parameter ADDR_W, default 16, giving the word-address width of the memory port.
REQ-003 The module SHALL have one clock and a synchronous, active-high reset; the clock port is clk and the reset port is reset.
REQ-004 clk  input  1  sole clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous active-high reset.
REQ-006 start  input  1  one-cycle pulse; begins a load when sampled in IDLE.
REQ-007 base_addr  input  ADDR_W  first word address; sampled with start.
REQ-008 word_count  input  ADDR_W  number of words to load; sampled with start.
REQ-009 in_data  input  8  firmware byte stream, little-endian within each word.
REQ-010 in_valid  input  1  in_data is valid.
REQ-011 in_ready  output  1  loader accepts the byte; transfer occurs when in_valid&in_ready.
REQ-012 mem_address  output  ADDR_W  word address to memory.
REQ-013 mem_byteenable  output  4  byte lanes; always 4'hF when mem_chipselect=1.
REQ-014 mem_chipselect  output  1  memory access this cycle.
REQ-015 mem_write  output  1  write strobe; only asserted together with mem_chipselect.
REQ-016 mem_writedata  output  32  word to write.
REQ-017 mem_readdata  input  32  memory read data, valid the cycle after the read address is presented.
REQ-018 cpu_reset_req  output  1  holds the processor in reset while a load is in progress.
REQ-019 busy, done, error  output  1 each  status flags.
REQ-020 checksum  output  32  modulo-2^32 sum of all words written.

Function
REQ-021 FSM states SHALL be IDLE, RECV, WRITE, VRD_ADDR, VRD_DATA, DONE.
REQ-022 IDLE: on start, latch base_addr, word_count; clear checksum, readback sum, word index, byte index, done, error; go to RECV; start outside IDLE SHALL be ignored.
REQ-023 If base_addr + word_count > MEM_WORDS (computed ADDR_W+1 bits wide), the FSM SHALL go to DONE with error=1 and issue no memory access.
REQ-024 If word_count = 0, the FSM SHALL go to DONE next cycle with error=0, checksum=0.
REQ-025 RECV: in_ready=1; each accepted byte k (k=0..3) SHALL be placed in bits 8k+7:8k of the word; after byte 3, go to WRITE.
REQ-026 WRITE (exactly one cycle): mem_chipselect=1, mem_write=1, mem_byteenable=4'hF, mem_address=base+index, mem_writedata=assembled word; checksum += word (wraps); index++; in_ready=0.
REQ-027 After WRITE, the FSM SHALL go to RECV if index < word_count, else reset index to 0 and go to VRD_ADDR.
REQ-028 VRD_ADDR: mem_chipselect=1, mem_write=0, mem_address=base+index; next state VRD_DATA.
REQ-029 VRD_DATA: readback sum += mem_readdata; index++; go to VRD_ADDR if index < word_count, else DONE with error = (readback sum != checksum).
REQ-030 busy SHALL be 1 in every state except IDLE and DONE; cpu_reset_req SHALL equal busy.
REQ-031 DONE: done=1, error and checksum held; start SHALL launch a new load exactly as in IDLE.
REQ-032 in_ready SHALL be 0 in every state except RECV; bytes presented outside RECV are not consumed.
REQ-033 All outputs SHALL be registered or decoded from registered state only; no combinational path from in_valid to in_ready.

Reset
REQ-034 On reset, the FSM SHALL enter IDLE and all outputs SHALL be 0 (in_ready, mem_*, cpu_reset_req, busy, done, error, checksum).
REQ-035 Reset asserted mid-load SHALL take effect the next edge; no further memory write SHALL be issued and a partial word SHALL be discarded.

Structure
REQ-036 Package firmware_loader_pkg SHALL hold the state enum, MEM_WORDS default and byteenable constant 4'hF.
REQ-037 Byte-to-word assembly (byte index, shift, word-complete flag) SHALL be sub-module firmware_loader_packer.

Verification
REQ-038 base=0x0010, count=2, bytes 78 56 34 12 EF BE AD DE -> writes 0x12345678@0x0010, 0xDEADBEEF@0x0011; checksum=0xF0E21567, done=1, error=0.
REQ-039 Same load with in_valid toggled every other cycle -> identical writes; in_ready=0 in every WRITE cycle; no byte lost or duplicated.
REQ-040 base=51199, count=2 -> done=1, error=1 within 2 cycles of start; mem_chipselect never asserted.
REQ-041 count=0 -> done=1, error=0, checksum=0 one cycle after start; cpu_reset_req pulses 1 cycle.
REQ-042 Words 0xFFFFFFFF, 0x00000002 with memory model corrupting the second word on readback -> checksum=0x00000001, error=1.
REQ-043 Reset after 2 bytes of word 1 -> all outputs 0 next cycle; no mem_write afterward; fresh start loads correctly.

Source files
------------

// File: rtl/firmware_loader_pkg.sv
// Shared types and constants for the firmware loader: FSM state encoding,
// default memory depth and the full-word byte-enable pattern.
package firmware_loader_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_RECV,
    ST_WRITE,
    ST_VRD_ADDR,
    ST_VRD_DATA,
    ST_DONE
  } state_t;

  localparam int         MEM_WORDS_DEFAULT = 51200;
  localparam logic [3:0] BYTEEN_ALL        = 4'hF;

endpackage

// File: rtl/firmware_loader_packer.sv
// Assembles a little-endian byte stream into 32-bit words; flags the byte
// that completes a word so the loader can move to its write cycle.
module firmware_loader_packer (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_clear,
  input  logic        i_accept,
  input  logic [7:0]  i_byte,
  output logic [31:0] o_word,
  output logic        o_word_done
);

  logic [1:0]  r_byte_idx;
  logic [31:0] r_word;

  always_ff @(posedge clk) begin
    if (reset || i_clear) begin
      r_byte_idx <= 2'd0;
    end else if (i_accept) begin
      r_byte_idx <= r_byte_idx + 2'd1;
    end
  end

  // Word storage carries no reset; clearing the lane index is what discards a partial word.
  always_ff @(posedge clk) begin
    if (i_accept) begin
      r_word[{r_byte_idx, 3'b000} +: 8] <= i_byte;
    end
  end

  assign o_word      = r_word;
  assign o_word_done = i_accept && (r_byte_idx == 2'd3);

endmodule

// File: rtl/firmware_loader.sv
// Streams firmware bytes into on-chip memory as 32-bit words, then reads every
// word back and compares the readback sum with the write checksum.
module firmware_loader
  import firmware_loader_pkg::*;
#(
  parameter int MEM_WORDS = MEM_WORDS_DEFAULT,
  parameter int ADDR_W    = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] word_count,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic [ADDR_W-1:0] mem_address,
  output logic [3:0]        mem_byteenable,
  output logic              mem_chipselect,
  output logic              mem_write,
  output logic [31:0]       mem_writedata,
  input  logic [31:0]       mem_readdata,
  output logic              cpu_reset_req,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [31:0]       checksum
);

  localparam logic [ADDR_W:0] LIMIT = (ADDR_W+1)'(MEM_WORDS);
  localparam logic [ADDR_W:0] ONE   = (ADDR_W+1)'(1);

  state_t            r_state;
  logic [ADDR_W-1:0] r_base;
  logic [ADDR_W-1:0] r_count;
  logic [ADDR_W-1:0] r_idx;
  logic [31:0]       r_checksum;
  logic [31:0]       r_rbsum;
  logic              r_error;
  logic              r_skip;
  logic              r_ovf;

  logic              w_launch;
  logic              w_accept;
  logic              w_ovf;
  logic [ADDR_W:0]   w_idx_ext;
  logic              w_more;
  logic [ADDR_W-1:0] w_addr;
  logic [31:0]       w_rbsum_next;
  logic [31:0]       w_word;
  logic              w_word_done;

  assign w_launch     = start && ((r_state == ST_IDLE) || (r_state == ST_DONE));
  assign w_accept     = in_valid && in_ready;
  assign w_ovf        = ({1'b0, base_addr} + {1'b0, word_count}) > LIMIT;
  assign w_idx_ext    = {1'b0, r_idx} + ONE;
  assign w_more       = w_idx_ext < {1'b0, r_count};
  assign w_addr       = r_base + r_idx;
  assign w_rbsum_next = r_rbsum + mem_readdata;

  firmware_loader_packer u_packer (
    .clk         (clk),
    .reset       (reset),
    .i_clear     (w_launch),
    .i_accept    (w_accept),
    .i_byte      (in_data),
    .o_word      (w_word),
    .o_word_done (w_word_done)
  );

  always_ff @(posedge clk) begin
    if (w_launch) begin
      r_base  <= base_addr;
      r_count <= word_count;
    end
  end

  // Rejected or empty loads still pass through RECV for one cycle (r_skip) so
  // the processor-reset request is seen as a single-cycle pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= ST_IDLE;
      r_idx      <= '0;
      r_checksum <= 32'h0;
      r_rbsum    <= 32'h0;
      r_error    <= 1'b0;
      r_skip     <= 1'b0;
      r_ovf      <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE, ST_DONE: begin
          if (start) begin
            r_idx      <= '0;
            r_checksum <= 32'h0;
            r_rbsum    <= 32'h0;
            r_error    <= 1'b0;
            r_skip     <= w_ovf || (word_count == '0);
            r_ovf      <= w_ovf;
            r_state    <= ST_RECV;
          end
        end
        ST_RECV: begin
          if (r_skip) begin
            r_error <= r_ovf;
            r_state <= ST_DONE;
          end else if (w_word_done) begin
            r_state <= ST_WRITE;
          end
        end
        ST_WRITE: begin
          r_checksum <= r_checksum + w_word;
          if (w_more) begin
            r_idx   <= w_idx_ext[ADDR_W-1:0];
            r_state <= ST_RECV;
          end else begin
            r_idx   <= '0;
            r_state <= ST_VRD_ADDR;
          end
        end
        ST_VRD_ADDR: begin
          r_state <= ST_VRD_DATA;
        end
        ST_VRD_DATA: begin
          r_rbsum <= w_rbsum_next;
          if (w_more) begin
            r_idx   <= w_idx_ext[ADDR_W-1:0];
            r_state <= ST_VRD_ADDR;
          end else begin
            r_error <= (w_rbsum_next != r_checksum);
            r_state <= ST_DONE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory-side outputs are forced to zero whenever no access is in progress.
  assign mem_chipselect = (r_state == ST_WRITE) || (r_state == ST_VRD_ADDR);
  assign mem_write      = (r_state == ST_WRITE);
  assign mem_byteenable = mem_chipselect ? BYTEEN_ALL : 4'h0;
  assign mem_address    = mem_chipselect ? w_addr : '0;
  assign mem_writedata  = mem_write ? w_word : 32'h0;
  assign in_ready       = (r_state == ST_RECV) && !r_skip;
  assign busy           = (r_state != ST_IDLE) && (r_state != ST_DONE);
  assign cpu_reset_req  = busy;
  assign done           = (r_state == ST_DONE);
  assign error          = r_error;
  assign checksum       = r_checksum;

endmodule

// File: tb/tb_firmware_loader.sv
// Self-checking bench for firmware_loader: memory model with optional readback
// corruption, write monitor, and a word-level reference model of each load.
module tb_firmware_loader;

  localparam int MEM_WORDS = 51200;
  localparam int ADDR_W    = 16;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [15:0] base_addr;
  logic [15:0] word_count;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic [15:0] mem_address;
  logic [3:0]  mem_byteenable;
  logic        mem_chipselect;
  logic        mem_write;
  logic [31:0] mem_writedata;
  logic [31:0] mem_readdata = 32'h0;
  logic        cpu_reset_req;
  logic        busy;
  logic        done;
  logic        error;
  logic [31:0] checksum;

  logic [31:0] mem_model [int];
  int          corrupt_addr = -1;
  logic [15:0] wr_addr_q [$];
  logic [31:0] wr_data_q [$];
  int          cs_cnt   = 0;
  int          rdy_viol = 0;
  int          be_viol  = 0;
  int          checks   = 0;
  int          failures = 0;

  firmware_loader #(.MEM_WORDS(MEM_WORDS), .ADDR_W(ADDR_W)) dut (
    .clk            (clk),
    .reset          (reset),
    .start          (start),
    .base_addr      (base_addr),
    .word_count     (word_count),
    .in_data        (in_data),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .mem_address    (mem_address),
    .mem_byteenable (mem_byteenable),
    .mem_chipselect (mem_chipselect),
    .mem_write      (mem_write),
    .mem_writedata  (mem_writedata),
    .mem_readdata   (mem_readdata),
    .cpu_reset_req  (cpu_reset_req),
    .busy           (busy),
    .done           (done),
    .error          (error),
    .checksum       (checksum)
  );

  always #5 clk = ~clk;

  // Memory model (one-cycle read latency) and write monitor.
  always @(posedge clk) begin
    if (mem_byteenable !== (mem_chipselect ? 4'hF : 4'h0)) be_viol++;
    if (mem_write && !mem_chipselect) be_viol++;
    if (mem_chipselect) begin
      cs_cnt++;
      if (mem_write) begin
        wr_addr_q.push_back(mem_address);
        wr_data_q.push_back(mem_writedata);
        mem_model[int'(mem_address)] = mem_writedata;
        if (in_ready) rdy_viol++;
      end else begin
        mem_readdata <= (mem_model.exists(int'(mem_address)) ? mem_model[int'(mem_address)] : 32'h0)
                        ^ ((int'(mem_address) == corrupt_addr) ? 32'h0000_0100 : 32'h0);
      end
    end
  end

  function automatic logic [31:0] word_of(input logic [7:0] q [$], input int w);
    return {q[4*w+3], q[4*w+2], q[4*w+1], q[4*w]};
  endfunction

  function automatic logic [31:0] sum_of(input logic [7:0] q [$]);
    logic [31:0] s = 32'h0;
    for (int w = 0; w < q.size() / 4; w++) s += word_of(q, w);
    return s;
  endfunction

  task automatic do_start(input logic [15:0] b, input logic [15:0] c);
    @(negedge clk);
    base_addr  = b;
    word_count = c;
    start      = 1'b1;
    @(negedge clk);
    start      = 1'b0;
    base_addr  = 16'($urandom);
    word_count = 16'($urandom);
  endtask

  // mode 0: always valid, 1: valid every other cycle, 2: random valid plus a stray start pulse
  task automatic send_bytes(input logic [7:0] q [$], input int mode);
    int  i   = 0;
    int  cyc = 0;
    bit  v;
    while (i < q.size() && cyc < 4000) begin
      case (mode)
        0:       v = 1'b1;
        1:       v = (cyc % 2) == 0;
        default: v = 1'($urandom_range(0, 1));
      endcase
      start    = (mode == 2) && (cyc == 2);
      in_valid = v;
      in_data  = v ? q[i] : 8'($urandom);
      if (v && in_ready) i++;
      cyc++;
      @(negedge clk);
    end
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
  endtask

  task automatic wait_done(input int limit, output bit ok);
    ok = 1'b0;
    for (int k = 0; k < limit; k++) begin
      if (done) begin
        ok = 1'b1;
        break;
      end
      @(negedge clk);
    end
  endtask

  task automatic test_reset();
    checks++;
    if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error} !== 7'b0) begin
      failures++;
      $display("FAIL reset_flags: got %b required 0000000",
               {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error});
    end
    checks++;
    if (mem_byteenable !== 4'h0 || mem_address !== 16'h0 || mem_writedata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mem_bus: be=%h addr=%h wdata=%h required all 0",
               mem_byteenable, mem_address, mem_writedata);
    end
    checks++;
    if (checksum !== 32'h0) begin
      failures++;
      $display("FAIL reset_checksum: got %h required 00000000", checksum);
    end
  endtask

  task automatic test_basic();
    logic [7:0]  b [$];
    logic [31:0] exp_w [2];
    int          n0;
    bit          ok;
    b     = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    exp_w = '{32'h12345678, 32'hDEADBEEF};
    n0    = wr_addr_q.size();
    do_start(16'h0010, 16'd2);
    send_bytes(b, 0);
    wait_done(200, ok);
    checks++;
    if (!ok) begin failures++; $display("FAIL basic_done: done=%b required 1", done); end
    checks++;
    if (wr_addr_q.size() - n0 != 2) begin
      failures++;
      $display("FAIL basic_write_count: got %0d required 2", wr_addr_q.size() - n0);
    end
    for (int w = 0; w < 2; w++) begin
      if (n0 + w < wr_addr_q.size()) begin
        checks++;
        if (wr_addr_q[n0+w] !== 16'h0010 + 16'(w) || wr_data_q[n0+w] !== exp_w[w]) begin
          failures++;
          $display("FAIL basic_write%0d: got %h@%h required %h@%h", w,
                   wr_data_q[n0+w], wr_addr_q[n0+w], exp_w[w], 16'h0010 + 16'(w));
        end
      end
    end
    checks++;
    if (checksum !== 32'hF0E21567 || error !== 1'b0) begin
      failures++;
      $display("FAIL basic_result: checksum=%h error=%b required F0E21567 0", checksum, error);
    end
    checks++;
    if (busy !== 1'b0 || cpu_reset_req !== 1'b0) begin
      failures++;
      $display("FAIL basic_idle_flags: busy=%b cpu_reset_req=%b required 0 0", busy, cpu_reset_req);
    end
  endtask

  task automatic test_throttled();
    logic [7:0] b [$];
    int         n0, rv0;
    bit         ok;
    b   = '{8'h78, 8'h56, 8'h34, 8'h12, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
    n0  = wr_addr_q.size();
    rv0 = rdy_viol;
    do_start(16'h0010, 16'd2);
    send_bytes(b, 1);
    wait_done(200, ok);
    checks++;
    if (!ok || wr_addr_q.size() - n0 != 2) begin
      failures++;
      $display("FAIL throttle_done: done=%b writes=%0d required 1 2", done, wr_addr_q.size() - n0);
    end else begin
      checks++;
      if (wr_data_q[n0] !== 32'h12345678 || wr_data_q[n0+1] !== 32'hDEADBEEF ||
          wr_addr_q[n0] !== 16'h0010 || wr_addr_q[n0+1] !== 16'h0011) begin
        failures++;
        $display("FAIL throttle_writes: got %h@%h %h@%h required 12345678@0010 deadbeef@0011",
                 wr_data_q[n0], wr_addr_q[n0], wr_data_q[n0+1], wr_addr_q[n0+1]);
      end
    end
    checks++;
    if (rdy_viol != rv0) begin
      failures++;
      $display("FAIL throttle_ready_in_write: got %0d write cycles with in_ready=1 required 0", rdy_viol - rv0);
    end
    checks++;
    if (checksum !== 32'hF0E21567 || error !== 1'b0) begin
      failures++;
      $display("FAIL throttle_result: checksum=%h error=%b required F0E21567 0", checksum, error);
    end
  endtask

  task automatic test_overflow();
    int cs0;
    cs0 = cs_cnt;
    in_valid = 1'b1;
    in_data  = 8'hA5;
    do_start(16'd51199, 16'd2);
    if (!done) @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b1) begin
      failures++;
      $display("FAIL overflow_result: done=%b error=%b required 1 1", done, error);
    end
    repeat (4) @(negedge clk);
    in_valid = 1'b0;
    checks++;
    if (cs_cnt != cs0) begin
      failures++;
      $display("FAIL overflow_no_access: got %0d chipselect cycles required 0", cs_cnt - cs0);
    end
  endtask

  task automatic test_boundary();
    logic [7:0] b [$];
    int         n0;
    bit         ok;
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    n0 = wr_addr_q.size();
    do_start(16'd51198, 16'd2);
    send_bytes(b, 0);
    wait_done(200, ok);
    checks++;
    if (!ok || error !== 1'b0 || checksum !== sum_of(b)) begin
      failures++;
      $display("FAIL boundary_result: done=%b error=%b checksum=%h required 1 0 %h",
               done, error, checksum, sum_of(b));
    end
    checks++;
    if (wr_addr_q.size() - n0 != 2 || wr_addr_q[n0+1] !== 16'd51199 || wr_data_q[n0+1] !== word_of(b, 1)) begin
      failures++;
      $display("FAIL boundary_last_write: writes=%0d required 2 ending %h@%h",
               wr_addr_q.size() - n0, word_of(b, 1), 16'd51199);
    end
  endtask

  task automatic test_zero_count();
    int cs0;
    cs0 = cs_cnt;
    do_start(16'h0100, 16'd0);
    checks++;
    if (cpu_reset_req !== 1'b1 || busy !== 1'b1 || done !== 1'b0) begin
      failures++;
      $display("FAIL zero_pulse_on: cpu_reset_req=%b busy=%b done=%b required 1 1 0", cpu_reset_req, busy, done);
    end
    @(negedge clk);
    checks++;
    if (done !== 1'b1 || error !== 1'b0 || checksum !== 32'h0 || cpu_reset_req !== 1'b0) begin
      failures++;
      $display("FAIL zero_result: done=%b error=%b checksum=%h cpu_reset_req=%b required 1 0 00000000 0",
               done, error, checksum, cpu_reset_req);
    end
    checks++;
    if (cs_cnt != cs0) begin
      failures++;
      $display("FAIL zero_no_access: got %0d chipselect cycles required 0", cs_cnt - cs0);
    end
  endtask

  task automatic test_corrupt();
    logic [7:0] b [$];
    bit         ok;
    b = '{8'hFF, 8'hFF, 8'hFF, 8'hFF, 8'h02, 8'h00, 8'h00, 8'h00};
    corrupt_addr = 16'h0041;
    do_start(16'h0040, 16'd2);
    send_bytes(b, 0);
    wait_done(200, ok);
    corrupt_addr = -1;
    checks++;
    if (!ok || checksum !== 32'h00000001 || error !== 1'b1) begin
      failures++;
      $display("FAIL corrupt_result: done=%b checksum=%h error=%b required 1 00000001 1", done, checksum, error);
    end
  endtask

  task automatic test_reset_midload();
    logic [7:0] part [$];
    logic [7:0] b [$];
    int         n0;
    bit         ok;
    part = '{8'h11, 8'h22};
    n0   = wr_addr_q.size();
    do_start(16'h0020, 16'd2);
    send_bytes(part, 0);
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if ({in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error} !== 7'b0 ||
        checksum !== 32'h0 || mem_byteenable !== 4'h0 || mem_address !== 16'h0 || mem_writedata !== 32'h0) begin
      failures++;
      $display("FAIL midreset_outputs: flags=%b checksum=%h required all 0",
               {in_ready, mem_chipselect, mem_write, cpu_reset_req, busy, done, error}, checksum);
    end
    reset = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (wr_addr_q.size() != n0) begin
      failures++;
      $display("FAIL midreset_no_write: got %0d writes required 0", wr_addr_q.size() - n0);
    end
    for (int i = 0; i < 8; i++) b.push_back(8'($urandom));
    do_start(16'h0020, 16'd2);
    send_bytes(b, 0);
    wait_done(200, ok);
    checks++;
    if (!ok || wr_addr_q.size() - n0 != 2 || wr_data_q[n0] !== word_of(b, 0) ||
        wr_data_q[n0+1] !== word_of(b, 1) || checksum !== sum_of(b) || error !== 1'b0) begin
      failures++;
      $display("FAIL midreset_reload: checksum=%h error=%b required %h 0", checksum, error, sum_of(b));
    end
  endtask

  task automatic test_back_to_back();
    for (int t = 0; t < 6; t++) begin
      logic [7:0]  b [$];
      logic [15:0] base;
      int          cnt, n0, bad;
      bit          ok;
      cnt  = $urandom_range(1, 5);
      base = 16'($urandom_range(0, MEM_WORDS - cnt));
      for (int i = 0; i < 4 * cnt; i++) b.push_back(8'($urandom));
      n0 = wr_addr_q.size();
      do_start(base, 16'(cnt));
      send_bytes(b, 2);
      wait_done(400, ok);
      bad = 0;
      if (wr_addr_q.size() - n0 != cnt) bad = 1;
      else
        for (int w = 0; w < cnt; w++)
          if (wr_addr_q[n0+w] !== base + 16'(w) || wr_data_q[n0+w] !== word_of(b, w)) bad = 1;
      checks++;
      if (!ok || bad != 0) begin
        failures++;
        $display("FAIL b2b_writes[%0d]: done=%b writes=%0d required 1 %0d matching model", t, done,
                 wr_addr_q.size() - n0, cnt);
      end
      checks++;
      if (checksum !== sum_of(b) || error !== 1'b0) begin
        failures++;
        $display("FAIL b2b_result[%0d]: checksum=%h error=%b required %h 0", t, checksum, error, sum_of(b));
      end
    end
  endtask

  initial begin
    reset      = 1'b1;
    start      = 1'b0;
    base_addr  = 16'h0;
    word_count = 16'h0;
    in_data    = 8'h0;
    in_valid   = 1'b0;
    repeat (3) @(negedge clk);
    test_reset();
    reset = 1'b0;
    @(negedge clk);
    test_reset();
    test_basic();
    test_throttled();
    test_overflow();
    test_boundary();
    test_zero_count();
    test_corrupt();
    test_reset_midload();
    test_back_to_back();
    checks++;
    if (be_viol != 0) begin
      failures++;
      $display("FAIL byteenable_strobe: got %0d bad cycles required 0", be_viol);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

endmodule
